lab3_mem_blocking_cache_base_ctrl: RTL and testbench



---
 rtl/lab3_mem_cache_pkg.sv | 25 ++
 rtl/lab3_mem_line_status_array.sv | 37 +++
 rtl/lab3_mem_blocking_cache_base_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_lab3_mem_blocking_cache_base_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_mem_cache_pkg.sv
// Shared state, request-type and select encodings for the blocking cache control unit.
package lab3_mem_cache_pkg;

    localparam int unsigned NumLines = 16;

    typedef enum logic [3:0] {
        StIdle, StTc, StIn, StRd, StWd, StEp, StEr, StEw, StRr, StRw, StRu, StW
    } state_e;

    localparam logic [2:0] TypeRead  = 3'd0;
    localparam logic [2:0] TypeWrite = 3'd1;
    localparam logic [2:0] TypeInit  = 3'd2;

    localparam logic       WdataSelWord    = 1'b0;
    localparam logic       WdataSelMem     = 1'b1;
    localparam logic       MemAddrSelEvict = 1'b0;
    localparam logic       MemAddrSelReq   = 1'b1;
    localparam logic [2:0] RdWordSelZero   = 3'd4;

    // Byte enables covering one 32-bit word of a 16 B line.
    function automatic logic [15:0] word_wben(input logic [1:0] word);
        return 16'hF << {word, 2'b00};
    endfunction

endpackage

// File: rtl/lab3_mem_line_status_array.sv
// Per-line valid/dirty bits for the 16-line cache; async reset clears every line.
module lab3_mem_line_status_array
    import lab3_mem_cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_idx,
    input  logic       i_valid_set,
    input  logic       i_dirty_set,
    input  logic       i_dirty_clr,
    output logic       o_valid,
    output logic       o_dirty
);

    logic [NumLines-1:0] r_valid;
    logic [NumLines-1:0] r_dirty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_valid_set) begin
                r_valid[i_idx] <= 1'b1;
            end
            if (i_dirty_set) begin
                r_dirty[i_idx] <= 1'b1;
            end else if (i_dirty_clr) begin
                r_dirty[i_idx] <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];

endmodule

// File: rtl/lab3_mem_blocking_cache_base_ctrl.sv
// Control FSM for the blocking direct-mapped 256 B cache (16 x 16 B lines).
// Optional hit/miss counters: define LAB3_MEM_CACHE_CTRL_PERF_CNT_EN.
module lab3_mem_blocking_cache_base_ctrl
    import lab3_mem_cache_pkg::*;
#(
    parameter int unsigned p_idx_shamt = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cachereq_val,
    output logic        cachereq_rdy,
    output logic        cacheresp_val,
    input  logic        cacheresp_rdy,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    input  logic        memresp_val,
    output logic        memresp_rdy,
    output logic        cachereq_en,
    output logic        memresp_en,
    output logic        write_data_mux_sel,
    output logic        tag_array_ren,
    output logic        tag_array_wen,
    output logic        data_array_ren,
    output logic        data_array_wen,
    output logic [15:0] data_array_wben,
    output logic        read_data_reg_en,
    output logic        evict_addr_reg_en,
    output logic        memreq_addr_mux_sel,
    output logic [1:0]  hit,
    output logic [2:0]  read_word_mux_sel,
    output logic [2:0]  cacheresp_type,
    output logic [2:0]  memreq_type,
    input  logic [2:0]  cachereq_type,
    input  logic [31:0] cachereq_addr,
    input  logic        tag_match
`ifdef LAB3_MEM_CACHE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] num_hits,
    output logic [31:0] num_misses
`endif
);

    state_e     r_state;
    state_e     w_next;
    logic       r_hit;
    logic [3:0] w_idx;
    logic [1:0] w_word;
    logic       w_is_init;
    logic       w_is_write;
    logic       w_line_valid;
    logic       w_line_dirty;
    logic       w_hit;
    logic       w_valid_set;
    logic       w_dirty_set;
    logic       w_dirty_clr;
    logic       w_unused_addr;

    assign w_idx      = cachereq_addr[7+p_idx_shamt:4+p_idx_shamt];
    assign w_word     = cachereq_addr[3:2];
    assign w_is_init  = (cachereq_type == TypeInit);
    assign w_is_write = (cachereq_type == TypeWrite);
    assign w_hit      = tag_match & w_line_valid;
    // Tag bits are compared in the datapath, not here.
    assign w_unused_addr = ^cachereq_addr;

    lab3_mem_line_status_array u_status (
        .clk        (clk),
        .reset      (reset),
        .i_idx      (w_idx),
        .i_valid_set(w_valid_set),
        .i_dirty_set(w_dirty_set),
        .i_dirty_clr(w_dirty_clr),
        .o_valid    (w_line_valid),
        .o_dirty    (w_line_dirty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit <= 1'b0;
        end else if (r_state == StTc) begin
            r_hit <= ~w_is_init & w_hit;
        end
    end

    always_comb begin
        w_next              = r_state;
        cachereq_rdy        = 1'b0;
        cacheresp_val       = 1'b0;
        memreq_val          = 1'b0;
        memresp_rdy         = 1'b0;
        cachereq_en         = 1'b0;
        memresp_en          = 1'b0;
        write_data_mux_sel  = WdataSelWord;
        tag_array_ren       = 1'b0;
        tag_array_wen       = 1'b0;
        data_array_ren      = 1'b0;
        data_array_wen      = 1'b0;
        data_array_wben     = 16'h0000;
        read_data_reg_en    = 1'b0;
        evict_addr_reg_en   = 1'b0;
        memreq_addr_mux_sel = MemAddrSelEvict;
        hit                 = 2'b00;
        read_word_mux_sel   = 3'd0;
        cacheresp_type      = 3'd0;
        memreq_type         = 3'd0;
        w_valid_set         = 1'b0;
        w_dirty_set         = 1'b0;
        w_dirty_clr         = 1'b0;

        unique case (r_state)
            StIdle: begin
                // Keep the handshake quiet while reset is still asserted.
                if (!reset) begin
                    cachereq_rdy = 1'b1;
                    if (cachereq_val) begin
                        cachereq_en = 1'b1;
                        w_next      = StTc;
                    end
                end
            end
            StTc: begin
                tag_array_ren = 1'b1;
                if (w_is_init) begin
                    w_next = StIn;
                end else if (w_hit) begin
                    w_next = w_is_write ? StWd : StRd;
                end else if (w_line_valid && w_line_dirty) begin
                    w_next = StEp;
                end else begin
                    w_next = StRr;
                end
            end
            StIn: begin
                tag_array_wen      = 1'b1;
                data_array_wen     = 1'b1;
                data_array_wben    = word_wben(w_word);
                write_data_mux_sel = WdataSelWord;
                w_valid_set        = 1'b1;
                w_dirty_clr        = 1'b1;
                w_next             = StW;
            end
            StRd: begin
                data_array_ren   = 1'b1;
                read_data_reg_en = 1'b1;
                w_next           = StW;
            end
            StWd: begin
                data_array_wen     = 1'b1;
                data_array_wben    = word_wben(w_word);
                write_data_mux_sel = WdataSelWord;
                w_dirty_set        = 1'b1;
                w_next             = StW;
            end
            StEp: begin
                tag_array_ren     = 1'b1;
                data_array_ren    = 1'b1;
                read_data_reg_en  = 1'b1;
                evict_addr_reg_en = 1'b1;
                w_next            = StEr;
            end
            StEr: begin
                memreq_val          = 1'b1;
                memreq_type         = TypeWrite;
                memreq_addr_mux_sel = MemAddrSelEvict;
                if (memreq_rdy) begin
                    w_next = StEw;
                end
            end
            StEw: begin
                memresp_rdy = 1'b1;
                if (memresp_val) begin
                    w_next = StRr;
                end
            end
            StRr: begin
                memreq_val          = 1'b1;
                memreq_type         = TypeRead;
                memreq_addr_mux_sel = MemAddrSelReq;
                if (memreq_rdy) begin
                    w_next = StRw;
                end
            end
            StRw: begin
                memresp_rdy = 1'b1;
                memresp_en  = 1'b1;
                if (memresp_val) begin
                    w_next = StRu;
                end
            end
            StRu: begin
                tag_array_wen      = 1'b1;
                data_array_wen     = 1'b1;
                data_array_wben    = 16'hFFFF;
                write_data_mux_sel = WdataSelMem;
                w_valid_set        = 1'b1;
                w_dirty_clr        = 1'b1;
                w_next             = w_is_write ? StWd : StRd;
            end
            StW: begin
                cacheresp_val  = 1'b1;
                cacheresp_type = cachereq_type;
                hit            = {1'b0, r_hit};
                // Types other than write/init behave as reads.
                if (w_is_write || w_is_init) begin
                    read_word_mux_sel = RdWordSelZero;
                end else begin
                    read_word_mux_sel = 3'd3 - {1'b0, w_word};
                end
                if (cacheresp_rdy) begin
                    w_next = StIdle;
                end
            end
            default: begin
                w_next = StIdle;
            end
        endcase
    end

`ifdef LAB3_MEM_CACHE_CTRL_PERF_CNT_EN
    logic [31:0] r_num_hits;
    logic [31:0] r_num_misses;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_hits   <= 32'd0;
            r_num_misses <= 32'd0;
        end else if (r_state == StTc && !w_is_init) begin
            if (w_hit) begin
                r_num_hits <= r_num_hits + 32'd1;
            end else begin
                r_num_misses <= r_num_misses + 32'd1;
            end
        end
    end

    assign num_hits   = r_num_hits;
    assign num_misses = r_num_misses;
`endif

endmodule

// File: tb/tb_lab3_mem_blocking_cache_base_ctrl.sv
// Randomized bench for the blocking cache control unit against a line-level cache model.
module tb_lab3_mem_blocking_cache_base_ctrl;

    localparam int IdxShamt = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
    logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic        cachereq_en, memresp_en, write_data_mux_sel;
    logic        tag_array_ren, tag_array_wen, data_array_ren, data_array_wen;
    logic [15:0] data_array_wben;
    logic        read_data_reg_en, evict_addr_reg_en, memreq_addr_mux_sel;
    logic [1:0]  hit;
    logic [2:0]  read_word_mux_sel, cacheresp_type, memreq_type, cachereq_type;
    logic [31:0] cachereq_addr;
    logic        tag_match;
`ifdef LAB3_MEM_CACHE_CTRL_PERF_CNT_EN
    logic [31:0] num_hits, num_misses;
    int          m_hits, m_misses;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [31:0] m_tag [16];

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> (4 + IdxShamt)) & 32'hF);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (8 + IdxShamt);
    endfunction

    // The tag array lives in the datapath; the model's tags stand in for it.
    assign tag_match = (m_tag[idx_of(cachereq_addr)] == tag_of(cachereq_addr));

    lab3_mem_blocking_cache_base_ctrl #(.p_idx_shamt(IdxShamt)) dut (
        .clk                (clk),
        .reset              (reset),
        .cachereq_val       (cachereq_val),
        .cachereq_rdy       (cachereq_rdy),
        .cacheresp_val      (cacheresp_val),
        .cacheresp_rdy      (cacheresp_rdy),
        .memreq_val         (memreq_val),
        .memreq_rdy         (memreq_rdy),
        .memresp_val        (memresp_val),
        .memresp_rdy        (memresp_rdy),
        .cachereq_en        (cachereq_en),
        .memresp_en         (memresp_en),
        .write_data_mux_sel (write_data_mux_sel),
        .tag_array_ren      (tag_array_ren),
        .tag_array_wen      (tag_array_wen),
        .data_array_ren     (data_array_ren),
        .data_array_wen     (data_array_wen),
        .data_array_wben    (data_array_wben),
        .read_data_reg_en   (read_data_reg_en),
        .evict_addr_reg_en  (evict_addr_reg_en),
        .memreq_addr_mux_sel(memreq_addr_mux_sel),
        .hit                (hit),
        .read_word_mux_sel  (read_word_mux_sel),
        .cacheresp_type     (cacheresp_type),
        .memreq_type        (memreq_type),
        .cachereq_type      (cachereq_type),
        .cachereq_addr      (cachereq_addr),
        .tag_match          (tag_match)
`ifdef LAB3_MEM_CACHE_CTRL_PERF_CNT_EN
        ,
        .num_hits           (num_hits),
        .num_misses         (num_misses)
`endif
    );

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {23'd0, cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy, cachereq_en,
                memresp_en, write_data_mux_sel, tag_array_ren, tag_array_wen, data_array_ren,
                data_array_wen, data_array_wben, read_data_reg_en, evict_addr_reg_en,
                memreq_addr_mux_sel, hit, read_word_mux_sel, cacheresp_type, memreq_type};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 32'hFFFF_FFFF;
        end
`ifdef LAB3_MEM_CACHE_CTRL_PERF_CNT_EN
        m_hits   = 0;
        m_misses = 0;
`endif
    endtask

    task automatic run_txn(input logic [2:0] typ, input logic [31:0] addr);
        int          idx, n_mem, exp_lat, req_idx, waitcnt, resp_edge, c, tag_wen, exp_tag_wen;
        int          stall;
        int          w [2];
        int          l [2];
        bit          is_init, is_write, exp_hit, evict, pend, done, busy_rdy, consumed;
        logic [2:0]  exp_mtype [2];
        logic        exp_msel [2];
        logic [2:0]  got_mtype [2];
        logic        got_msel [2];
        logic [15:0] exp_wb [$];
        logic [15:0] got_wb [$];
        logic [1:0]  exp_hitf;
        logic [2:0]  exp_rw;

        idx      = idx_of(addr);
        is_init  = (typ == 3'd2);
        is_write = (typ == 3'd1);
        exp_hit  = !is_init && m_valid[idx] && (m_tag[idx] == tag_of(addr));
        evict    = !is_init && !exp_hit && m_valid[idx] && m_dirty[idx];
        n_mem    = (is_init || exp_hit) ? 0 : (evict ? 2 : 1);
        exp_lat  = 2;
        for (int i = 0; i < 2; i++) begin
            w[i] = int'($urandom_range(0, 2));
            l[i] = int'($urandom_range(1, 3));
            if (i < n_mem) exp_lat += 2 + w[i] + l[i];
        end
        exp_mtype[0] = evict ? 3'd1 : 3'd0;
        exp_msel[0]  = evict ? 1'b0 : 1'b1;
        exp_mtype[1] = 3'd0;
        exp_msel[1]  = 1'b1;
        if (n_mem > 0) exp_wb.push_back(16'hFFFF);
        if (is_init || is_write) exp_wb.push_back(16'hF << (4 * int'(addr[3:2])));
        exp_tag_wen = ((n_mem > 0) ? 1 : 0) + (is_init ? 1 : 0);
        exp_hitf    = {1'b0, exp_hit};
        exp_rw      = (is_init || is_write) ? 3'd4 : 3'd3 - {1'b0, addr[3:2]};

        @(negedge clk);
        check_val("req_rdy", cachereq_rdy, 1);
        cachereq_val  = 1'b1;
        cachereq_type = typ;
        cachereq_addr = addr;
        cacheresp_rdy = 1'b0;
        memreq_rdy    = 1'b0;
        memresp_val   = 1'b0;
        @(posedge clk);
        c = 0; req_idx = 0; waitcnt = 0; resp_edge = 0; tag_wen = 0;
        pend = 0; done = 0; busy_rdy = 0;
        while (c < 100) begin
            @(negedge clk);
            cachereq_val = 1'b0;
            if (cachereq_rdy) busy_rdy = 1'b1;
            if (data_array_wen) got_wb.push_back(data_array_wben);
            if (tag_array_wen) tag_wen++;
            if (cacheresp_val) begin
                done = 1'b1;
                break;
            end
            memresp_val = pend && (c + 1 >= resp_edge);
            consumed    = memresp_val && memresp_rdy;
            memreq_rdy  = 1'b0;
            if (memreq_val && !pend && req_idx < 2) begin
                if (waitcnt == w[req_idx]) begin
                    memreq_rdy         = 1'b1;
                    got_mtype[req_idx] = memreq_type;
                    got_msel[req_idx]  = memreq_addr_mux_sel;
                    resp_edge          = c + 1 + l[req_idx];
                    pend               = 1'b1;
                    req_idx++;
                    waitcnt = 0;
                end else begin
                    waitcnt++;
                end
            end
            @(posedge clk);
            c++;
            if (consumed) pend = 1'b0;
        end
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;

        check_val("resp_seen", done, 1);
        check_val("latency", c, exp_lat);
        check_val("resp_type", cacheresp_type, typ);
        check_val("resp_hit", hit, exp_hitf);
        check_val("rd_word_sel", read_word_mux_sel, exp_rw);
        check_val("rdy_busy", busy_rdy, 0);
        check_val("mreq_cnt", req_idx, n_mem);
        for (int i = 0; i < req_idx && i < n_mem; i++) begin
            check_val("mreq_type", got_mtype[i], exp_mtype[i]);
            check_val("mreq_addr_sel", got_msel[i], exp_msel[i]);
        end
        check_val("wben_cnt", got_wb.size(), exp_wb.size());
        for (int i = 0; i < got_wb.size() && i < exp_wb.size(); i++) begin
            check_val("wben", got_wb[i], exp_wb[i]);
        end
        check_val("tag_wen_cnt", tag_wen, exp_tag_wen);

        if (done) begin
            stall = int'($urandom_range(0, 4));
            repeat (stall) begin
                @(posedge clk);
                @(negedge clk);
                check_val("resp_hold",
                          {cacheresp_val, cachereq_rdy, hit, read_word_mux_sel, cacheresp_type},
                          {1'b1, 1'b0, exp_hitf, exp_rw, typ});
            end
            cacheresp_rdy = 1'b1;
            @(posedge clk);
            @(negedge clk);
            cacheresp_rdy = 1'b0;
            check_val("back_idle", {cachereq_rdy, cacheresp_val}, 2'b10);
        end

`ifdef LAB3_MEM_CACHE_CTRL_PERF_CNT_EN
        if (!is_init) begin
            if (exp_hit) m_hits++;
            else m_misses++;
        end
        check_val("num_hits", num_hits, m_hits);
        check_val("num_misses", num_misses, m_misses);
`endif
        if (is_init || !exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag_of(addr);
            m_dirty[idx] = 1'b0;
        end
        if (is_write) m_dirty[idx] = 1'b1;
    endtask

    task automatic reset_mid_refill(input logic [31:0] addr);
        @(negedge clk);
        cachereq_val  = 1'b1;
        cachereq_type = 3'd0;
        cachereq_addr = addr;
        @(posedge clk);
        @(negedge clk);
        cachereq_val = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (memreq_val) break;
            @(posedge clk);
            @(negedge clk);
        end
        check_val("rst_mreq", memreq_val, 1);
        memreq_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        memreq_rdy = 1'b0;
        check_val("rst_in_rw", {memresp_rdy, memresp_en}, 2'b11);
        cachereq_val = 1'b1;
        reset        = 1'b1;
        #1;
        check_val("rst_mid_outs", all_outs(), 0);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_mid_rdy", cachereq_rdy, 0);
        cachereq_val = 1'b0;
        reset        = 1'b0;
        model_reset();
        #1;
        check_val("rst_mid_idle", {cachereq_rdy, memreq_val, cacheresp_val}, 3'b100);
    endtask

    function automatic logic [2:0] pick_type();
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return 3'd0;
            4, 5, 6:    return 3'd1;
            7:          return 3'd2;
            8:          return 3'd3;
            default:    return 3'd6;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        cachereq_val  = 1'b0;
        cachereq_type = 3'd0;
        cachereq_addr = 32'd0;
        cacheresp_rdy = 1'b0;
        memreq_rdy    = 1'b0;
        memresp_val   = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        cachereq_val = 1'b1;
        #2;
        check_val("rst_outs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cachereq_val = 1'b0;
        reset        = 1'b0;
        #1;
        check_val("idle_rdy", cachereq_rdy, 1);

        run_txn(3'd2, 32'h0000_1000);
        run_txn(3'd0, 32'h0000_1000);
        run_txn(3'd0, 32'h0000_2004);
        run_txn(3'd0, 32'h0000_2004);
        run_txn(3'd1, 32'h0000_3008);
        run_txn(3'd0, 32'h0000_4008);

        reset_mid_refill(32'h0000_5010);
        run_txn(3'd0, 32'h0000_5010);
        run_txn(3'd0, 32'h0000_4008);

        for (int n = 0; n < 250; n++) begin
            a = ($urandom_range(1, 3) << (8 + IdxShamt)) | ($urandom_range(0, 3) << (4 + IdxShamt))
                | ($urandom_range(0, 3) << 2);
            run_txn(pick_type(), a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
